// File: rtl/powlib_busreg_resp.sv
// Write-bus sink: decodes an address window onto a register bank and returns the
// pre-write value of each in-window write on a one-deep response register.
module powlib_busreg_resp #(
  parameter int              B_AW   = 4,
  parameter int              B_DW   = 32,
  parameter int              B_BASE = 0,
  parameter int              B_SIZE = 4,
  parameter int              EW     = 8,
  parameter logic [B_DW-1:0] RV     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [B_DW-1:0]        wrdata,
  input  logic [B_AW-1:0]        wraddr,
  input  logic                   wrvld,
  output logic                   wrrdy,
  output logic [B_DW-1:0]        rspdata,
  output logic [B_AW-1:0]        rspaddr,
  output logic                   rspvld,
  input  logic                   rsprdy,
  output logic [B_SIZE*B_DW-1:0] regs,
  output logic [B_SIZE-1:0]      wrstb,
  output logic [EW-1:0]          errcnt
);

  typedef enum logic {ST_EMPTY, ST_FULL} rsp_state_e;

  // One extra bit so a window ending exactly at 2**B_AW never wraps onto address 0.
  localparam logic [B_AW:0] LP_BASE = (B_AW+1)'(B_BASE);
  localparam logic [B_AW:0] LP_END  = (B_AW+1)'(B_BASE + B_SIZE);

  rsp_state_e              r_state;
  rsp_state_e              w_state_nxt;
  logic [B_DW-1:0]         r_regs [B_SIZE];
  logic [B_DW-1:0]         r_rspdata;
  logic [B_AW-1:0]         r_rspaddr;
  logic [B_SIZE-1:0]       r_wrstb;
  logic [EW-1:0]           r_errcnt;

  logic [B_AW:0]           w_addr_ext;
  logic [B_AW-1:0]         w_idx;
  logic                    w_hit;
  logic                    w_acc;
  logic                    w_acc_hit;
  logic                    w_acc_miss;
  logic [B_SIZE-1:0]       w_sel;
  logic [B_DW-1:0]         w_old;

  assign w_addr_ext = {1'b0, wraddr};
  assign w_hit      = (w_addr_ext >= LP_BASE) && (w_addr_ext < LP_END);
  assign w_idx      = wraddr - B_AW'(B_BASE);

  assign wrrdy      = rst && ((r_state == ST_EMPTY) || rsprdy);
  assign w_acc      = wrvld && wrrdy;
  assign w_acc_hit  = w_acc && w_hit;
  assign w_acc_miss = w_acc && !w_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel = '0;
    w_old = '0;
    for (int i = 0; i < B_SIZE; i++) begin
      if (w_hit && (w_idx == B_AW'(i))) begin
        w_sel[i] = 1'b1;
        w_old    = r_regs[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc_hit) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsprdy && !w_acc_hit) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: the register bank is architecturally visible, so unlike a RAM it is reset, to RV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_EMPTY;
      r_rspdata <= '0;
      r_rspaddr <= '0;
      r_wrstb   <= '0;
      r_errcnt  <= '0;
      for (int i = 0; i < B_SIZE; i++) r_regs[i] <= RV;
    end else begin
      r_state <= w_state_nxt;
      r_wrstb <= w_acc ? w_sel : '0;
      if (w_acc_hit) begin
        r_rspdata <= w_old;
        r_rspaddr <= wraddr;
      end
      for (int i = 0; i < B_SIZE; i++) begin
        if (w_acc && w_sel[i]) r_regs[i] <= wrdata;
      end
      if (w_acc_miss && (r_errcnt != '1)) r_errcnt <= r_errcnt + 1'b1;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < B_SIZE; i++) regs[i*B_DW +: B_DW] = r_regs[i];
  end

  assign rspvld  = (r_state == ST_FULL);
  assign rspdata = r_rspdata;
  assign rspaddr = r_rspaddr;
  assign wrstb   = r_wrstb;
  assign errcnt  = r_errcnt;

endmodule

// File: tb/tb_powlib_busreg_resp.sv
// Directed bench: window [4,8) with EW=8 and EW=2 instances sharing stimulus,
// plus a window [12,16) instance for the top-of-space and reset-while-full cases.
module tb_powlib_busreg_resp;

  localparam logic [31:0] RV_A = 32'hDEAD_0000;
  localparam logic [31:0] RV_C = 32'h5555_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           chk_cnt = 0;
  int           pass_cnt = 0;

  logic [31:0]  a_wrdata = '0;
  logic [3:0]   a_wraddr = '0;
  logic         a_wrvld  = 1'b0;
  logic         a_rsprdy = 1'b1;
  logic         a_wrrdy, a_rspvld, s_wrrdy, s_rspvld;
  logic [31:0]  a_rspdata, s_rspdata;
  logic [3:0]   a_rspaddr, s_rspaddr, a_wrstb, s_wrstb;
  logic [127:0] a_regs, s_regs;
  logic [7:0]   a_errcnt;
  logic [1:0]   s_errcnt;

  logic [31:0]  c_wrdata = '0;
  logic [3:0]   c_wraddr = '0;
  logic         c_wrvld  = 1'b0;
  logic         c_rsprdy = 1'b1;
  logic         c_wrrdy, c_rspvld;
  logic [31:0]  c_rspdata;
  logic [3:0]   c_rspaddr, c_wrstb;
  logic [127:0] c_regs;
  logic [7:0]   c_errcnt;

  always #5 clk = ~clk;

  powlib_busreg_resp #(.B_AW(4), .B_DW(32), .B_BASE(4), .B_SIZE(4), .EW(8), .RV(RV_A)) dut_a (
    .clk(clk), .rst(rst), .wrdata(a_wrdata), .wraddr(a_wraddr), .wrvld(a_wrvld), .wrrdy(a_wrrdy),
    .rspdata(a_rspdata), .rspaddr(a_rspaddr), .rspvld(a_rspvld), .rsprdy(a_rsprdy),
    .regs(a_regs), .wrstb(a_wrstb), .errcnt(a_errcnt));

  powlib_busreg_resp #(.B_AW(4), .B_DW(32), .B_BASE(4), .B_SIZE(4), .EW(2), .RV(RV_A)) dut_s (
    .clk(clk), .rst(rst), .wrdata(a_wrdata), .wraddr(a_wraddr), .wrvld(a_wrvld), .wrrdy(s_wrrdy),
    .rspdata(s_rspdata), .rspaddr(s_rspaddr), .rspvld(s_rspvld), .rsprdy(a_rsprdy),
    .regs(s_regs), .wrstb(s_wrstb), .errcnt(s_errcnt));

  powlib_busreg_resp #(.B_AW(4), .B_DW(32), .B_BASE(12), .B_SIZE(4), .EW(8), .RV(RV_C)) dut_c (
    .clk(clk), .rst(rst), .wrdata(c_wrdata), .wraddr(c_wraddr), .wrvld(c_wrvld), .wrrdy(c_wrrdy),
    .rspdata(c_rspdata), .rspaddr(c_rspaddr), .rspvld(c_rspvld), .rsprdy(c_rsprdy),
    .regs(c_regs), .wrstb(c_wrstb), .errcnt(c_errcnt));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (a_wrrdy !== 1'b0) $display("FAIL reset.wrrdy_low got=%0h exp=0", a_wrrdy); else pass_cnt++;
    chk_cnt++; if (a_regs !== {4{RV_A}}) $display("FAIL reset.regs got=%h exp=%h", a_regs, {4{RV_A}}); else pass_cnt++;
    chk_cnt++; if (c_regs !== {4{RV_C}}) $display("FAIL reset.regs_c got=%h exp=%h", c_regs, {4{RV_C}}); else pass_cnt++;
    chk_cnt++; if ({a_rspvld, a_wrstb, a_errcnt, a_rspaddr, a_rspdata} !== '0)
      $display("FAIL reset.outputs got vld=%0h stb=%0h err=%0h addr=%0h data=%0h exp all 0",
               a_rspvld, a_wrstb, a_errcnt, a_rspaddr, a_rspdata);
    else pass_cnt++;
    rst = 1'b1;
    step();
    chk_cnt++; if (a_wrrdy !== 1'b1) $display("FAIL reset.wrrdy_after got=%0h exp=1", a_wrrdy); else pass_cnt++;
  endtask

  task automatic test_single_write();
    a_wraddr = 4'd5; a_wrdata = 32'hA5A5_A5A5; a_wrvld = 1'b1; a_rsprdy = 1'b1;
    step();
    a_wrvld = 1'b0;
    chk_cnt++; if (a_wrstb !== 4'b0010) $display("FAIL single.wrstb got=%b exp=0010", a_wrstb); else pass_cnt++;
    chk_cnt++; if (a_regs[32 +: 32] !== 32'hA5A5_A5A5) $display("FAIL single.reg1 got=%h exp=a5a5a5a5", a_regs[32 +: 32]); else pass_cnt++;
    chk_cnt++; if (a_regs[0 +: 32] !== RV_A) $display("FAIL single.reg0_untouched got=%h exp=%h", a_regs[0 +: 32], RV_A); else pass_cnt++;
    chk_cnt++; if (a_rspvld !== 1'b1 || a_rspaddr !== 4'd5 || a_rspdata !== RV_A)
      $display("FAIL single.rsp got vld=%0h addr=%0h data=%h exp 1/5/%h", a_rspvld, a_rspaddr, a_rspdata, RV_A);
    else pass_cnt++;
    step();
    chk_cnt++; if (a_wrstb !== 4'b0000 || a_rspvld !== 1'b0)
      $display("FAIL single.drain got stb=%b vld=%0h exp 0000/0", a_wrstb, a_rspvld);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    a_wraddr = 4'd6; a_wrdata = 32'd1; a_wrvld = 1'b1;
    #1;
    chk_cnt++; if (a_wrrdy !== 1'b1) $display("FAIL b2b.wrrdy0 got=%0h exp=1", a_wrrdy); else pass_cnt++;
    step();
    chk_cnt++; if (a_rspvld !== 1'b1 || a_rspaddr !== 4'd6 || a_rspdata !== RV_A)
      $display("FAIL b2b.rsp1 got vld=%0h addr=%0h data=%h exp 1/6/%h", a_rspvld, a_rspaddr, a_rspdata, RV_A);
    else pass_cnt++;
    a_wrdata = 32'd2;
    #1;
    chk_cnt++; if (a_wrrdy !== 1'b1) $display("FAIL b2b.wrrdy1 got=%0h exp=1", a_wrrdy); else pass_cnt++;
    step();
    a_wrvld = 1'b0;
    chk_cnt++; if (a_rspvld !== 1'b1 || a_rspdata !== 32'd1 || a_wrstb !== 4'b0100)
      $display("FAIL b2b.rsp2 got vld=%0h data=%h stb=%b exp 1/00000001/0100", a_rspvld, a_rspdata, a_wrstb);
    else pass_cnt++;
    chk_cnt++; if (a_regs[64 +: 32] !== 32'd2) $display("FAIL b2b.reg2 got=%h exp=00000002", a_regs[64 +: 32]); else pass_cnt++;
    step();
  endtask

  task automatic test_stall();
    a_wraddr = 4'd4; a_wrdata = 32'h11; a_wrvld = 1'b1; a_rsprdy = 1'b0;
    step();
    chk_cnt++; if (a_rspvld !== 1'b1 || a_rspaddr !== 4'd4 || a_rspdata !== RV_A || a_wrstb !== 4'b0001)
      $display("FAIL stall.first got vld=%0h addr=%0h data=%h stb=%b exp 1/4/%h/0001",
               a_rspvld, a_rspaddr, a_rspdata, a_wrstb, RV_A);
    else pass_cnt++;
    a_wraddr = 4'd7; a_wrdata = 32'h22;
    #1;
    chk_cnt++; if (a_wrrdy !== 1'b0) $display("FAIL stall.wrrdy_low got=%0h exp=0", a_wrrdy); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_cnt++; if (a_rspvld !== 1'b1 || a_rspaddr !== 4'd4 || a_rspdata !== RV_A || a_wrstb !== 4'b0000 ||
                     a_regs[96 +: 32] !== RV_A)
        $display("FAIL stall.hold%0d got vld=%0h addr=%0h data=%h stb=%b reg3=%h exp 1/4/%h/0000/%h",
                 k, a_rspvld, a_rspaddr, a_rspdata, a_wrstb, a_regs[96 +: 32], RV_A, RV_A);
      else pass_cnt++;
    end
    a_rsprdy = 1'b1;
    #1;
    chk_cnt++; if (a_wrrdy !== 1'b1) $display("FAIL stall.wrrdy_release got=%0h exp=1", a_wrrdy); else pass_cnt++;
    step();
    a_wrvld = 1'b0;
    chk_cnt++; if (a_rspvld !== 1'b1 || a_rspaddr !== 4'd7 || a_rspdata !== RV_A || a_wrstb !== 4'b1000 ||
                   a_regs[96 +: 32] !== 32'h22)
      $display("FAIL stall.reload got vld=%0h addr=%0h data=%h stb=%b reg3=%h exp 1/7/%h/1000/00000022",
               a_rspvld, a_rspaddr, a_rspdata, a_wrstb, a_regs[96 +: 32], RV_A);
    else pass_cnt++;
    step();
    chk_cnt++; if (a_rspvld !== 1'b0) $display("FAIL stall.drain got=%0h exp=0", a_rspvld); else pass_cnt++;
  endtask

  task automatic test_miss_saturate();
    logic [3:0] addrs [5] = '{4'd3, 4'd8, 4'd15, 4'd0, 4'd9};
    logic [7:0] exp_a [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [127:0] regs_before;
    regs_before = a_regs;
    a_rsprdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_wraddr = addrs[k]; a_wrdata = 32'hFFFF_0000 | k; a_wrvld = 1'b1;
      step();
      chk_cnt++; if (a_wrstb !== 4'b0000 || a_rspvld !== 1'b0 || a_errcnt !== exp_a[k] || s_errcnt !== exp_s[k])
        $display("FAIL miss.addr%0d got stb=%b vld=%0h err=%0d err_sat=%0d exp 0000/0/%0d/%0d",
                 addrs[k], a_wrstb, a_rspvld, a_errcnt, s_errcnt, exp_a[k], exp_s[k]);
      else pass_cnt++;
    end
    a_wrvld = 1'b0;
    chk_cnt++; if (a_regs !== regs_before) $display("FAIL miss.regs_unchanged got=%h exp=%h", a_regs, regs_before); else pass_cnt++;
  endtask

  task automatic test_top_window_reset();
    c_wraddr = 4'd0; c_wrdata = 32'h0BAD; c_wrvld = 1'b1; c_rsprdy = 1'b1;
    step();
    chk_cnt++; if (c_errcnt !== 8'd1 || c_wrstb !== 4'b0000 || c_rspvld !== 1'b0)
      $display("FAIL top.no_alias got err=%0d stb=%b vld=%0h exp 1/0000/0", c_errcnt, c_wrstb, c_rspvld);
    else pass_cnt++;
    c_wraddr = 4'd15; c_wrdata = 32'hCAFE; c_rsprdy = 1'b0;
    step();
    c_wrvld = 1'b0;
    chk_cnt++; if (c_wrstb !== 4'b1000 || c_regs[96 +: 32] !== 32'hCAFE || c_rspvld !== 1'b1 ||
                   c_rspaddr !== 4'd15 || c_rspdata !== RV_C)
      $display("FAIL top.hit15 got stb=%b reg3=%h vld=%0h addr=%0h data=%h exp 1000/0000cafe/1/15/%h",
               c_wrstb, c_regs[96 +: 32], c_rspvld, c_rspaddr, c_rspdata, RV_C);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (c_rspvld !== 1'b0 || c_wrrdy !== 1'b0 || c_errcnt !== 8'd0)
      $display("FAIL top.async_reset got vld=%0h rdy=%0h err=%0d exp 0/0/0", c_rspvld, c_wrrdy, c_errcnt);
    else pass_cnt++;
    chk_cnt++; if (c_regs !== {4{RV_C}} || a_regs !== {4{RV_A}})
      $display("FAIL top.regs_reset got c=%h a=%h exp c=%h a=%h", c_regs, a_regs, {4{RV_C}}, {4{RV_A}});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_miss_saturate();
    test_top_window_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
